// File: rtl/wb_slave_pipeline_rx_pkg.sv
// Shared widths, state encoding and helpers for the Wishbone
// packet receive slave.
package wb_slave_pipeline_rx_pkg;

    localparam int BUS_ADDRESS_WIDTH = 32;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int GRANULARITY       = 8;
    localparam int BUS_SEL_WIDTH     = BUS_DATA_WIDTH / GRANULARITY;
    localparam int BUS_TGA_WIDTH     = 4;
    localparam int BUS_TGC_WIDTH     = 4;
    localparam int MAX_PACKET_LENGHT = 8;

    typedef logic [BUS_DATA_WIDTH-1:0]    data_t;
    typedef logic [BUS_ADDRESS_WIDTH-1:0] adr_t;
    typedef logic [BUS_TGA_WIDTH-1:0]     tga_t;
    typedef logic [BUS_TGC_WIDTH-1:0]     tgc_t;

    typedef enum logic [1:0] {
        RX_IDLE       = 2'd0,
        RX_GRANT_WAIT = 2'd1,
        RX_RECEIVE    = 2'd2,
        RX_DRAIN      = 2'd3
    } rx_state_e;

    // Bits needed to hold the value n itself.
    function automatic int cnt_bits(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_slave_pipeline_rx_if.sv
// Wishbone classic-pipelined bus between the NIC master and the
// receive slave, including the slave-generated grant.
interface wb_slave_pipeline_rx_if;
    import wb_slave_pipeline_rx_pkg::*;

    logic               CYC_I;
    logic               STB_I;
    logic               WE_I;
    adr_t               ADR_I;
    data_t              DAT_I;
    logic [BUS_SEL_WIDTH-1:0] SEL_I;
    tga_t               TGA_I;
    tgc_t               TGC_I;
    logic [2:0]         CTI_I;
    data_t              DAT_O;
    logic               ACK_O;
    logic               ERR_O;
    logic               RTY_O;
    logic               STALL_O;
    logic               gnt_wb_o;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        output SEL_I, TGA_I, TGC_I, CTI_I,
        input  DAT_O, ACK_O, ERR_O, RTY_O, STALL_O,
        input  gnt_wb_o
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        input  SEL_I, TGA_I, TGC_I, CTI_I,
        output DAT_O, ACK_O, ERR_O, RTY_O, STALL_O,
        output gnt_wb_o
    );

endinterface

// File: rtl/wb_rx_packet_buffer.sv
// Packet storage: one write port, one asynchronous read port.
module wb_rx_packet_buffer
    import wb_slave_pipeline_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  data_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output data_t         rdata_o
);

    data_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_slave_pipeline_rx.sv
// Wishbone slave that collects a whole packet, one flit per beat,
// then replays it on a valid/ready flit port.
module wb_slave_pipeline_rx
    import wb_slave_pipeline_rx_pkg::*;
#(
    parameter int N_WAIT_CYCLE_GRANT = 0,
    parameter int N_MAX_BEAT         = MAX_PACKET_LENGHT
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_slave_pipeline_rx_if.slave bus,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output data_t                 out_data_o,
    output logic                  out_first_o,
    output logic                  out_last_o,
    output adr_t                  out_adr_o,
    output tga_t                  out_tga_o,
    output tgc_t                  out_tgc_o
);

    localparam int CW = cnt_bits(N_MAX_BEAT);
    localparam int AW = (N_MAX_BEAT > 1) ? $clog2(N_MAX_BEAT) : 1;
    localparam int WW = cnt_bits(N_WAIT_CYCLE_GRANT);
    localparam logic [CW-1:0] MAX_C  = CW'(N_MAX_BEAT);
    localparam logic [WW-1:0] WAIT_C = WW'(N_WAIT_CYCLE_GRANT);

    rx_state_e       state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   rd_q, rd_d;
    logic            ovf_q, ovf_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    adr_t            adr_q, adr_d;
    tga_t            tga_q, tga_d;
    tgc_t            tgc_q, tgc_d;
    logic            buf_we;
    data_t           rdata;
    logic            in_rx;
    logic            draining;
    logic            unused_bus;

    assign in_rx    = (state_q == RX_RECEIVE);
    assign draining = (state_q == RX_DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            tga_q   <= '0;
            tgc_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            tga_q   <= tga_d;
            tgc_q   <= tgc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        adr_d   = adr_q;
        tga_d   = tga_q;
        tgc_d   = tgc_q;
        buf_we  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (bus.CYC_I) begin
                    state_d = RX_GRANT_WAIT;
                    wait_d  = WAIT_C;
                end
            end
            RX_GRANT_WAIT: begin
                if (!bus.CYC_I) begin
                    state_d = RX_IDLE;
                end else if (wait_q == '0) begin
                    state_d = RX_RECEIVE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RX_RECEIVE: begin
                if (!bus.CYC_I) begin
                    // Empty or damaged packets are dropped here.
                    if (cnt_q == '0 || ovf_q) begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = RX_DRAIN;
                    end
                end else if (bus.STB_I) begin
                    if (cnt_q == '0) begin
                        adr_d = bus.ADR_I;
                        tga_d = bus.TGA_I;
                        tgc_d = bus.TGC_I;
                    end
                    if (bus.WE_I && cnt_q < MAX_C) begin
                        buf_we = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        ack_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end
                end
            end
            RX_DRAIN: begin
                if (out_ready_i) begin
                    if (rd_q == cnt_q - 1'b1) begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                        rd_d    = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    wb_rx_packet_buffer #(
        .DEPTH (N_MAX_BEAT),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (bus.DAT_I),
        .raddr_i (rd_q[AW-1:0]),
        .rdata_o (rdata)
    );

    assign bus.gnt_wb_o = in_rx;
    assign bus.STALL_O  = !in_rx;
    assign bus.ACK_O    = ack_q;
    assign bus.ERR_O    = err_q;
    assign bus.RTY_O    = 1'b0;
    assign bus.DAT_O    = '0;

    assign out_valid_o = draining;
    assign out_data_o  = draining ? rdata : '0;
    assign out_first_o = draining && (rd_q == '0);
    assign out_last_o  = draining && (rd_q == cnt_q - 1'b1);
    assign out_adr_o   = adr_q;
    assign out_tga_o   = tga_q;
    assign out_tgc_o   = tgc_q;

    assign unused_bus = ^{bus.SEL_I, bus.CTI_I};

endmodule

// File: tb/tb_wb_slave_pipeline_rx.sv
// Directed bench for wb_slave_pipeline_rx with a packet-level
// reference model and a per-cycle flit checker.
module tb_wb_slave_pipeline_rx;
    import wb_slave_pipeline_rx_pkg::*;

    localparam int N_WAIT = 2;
    localparam int N_MAX  = 5;

    typedef struct {
        data_t data;
        logic  first;
        logic  last;
        adr_t  adr;
        tga_t  tga;
        tgc_t  tgc;
    } flit_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  out_valid_o;
    logic  out_ready_i = 1'b0;
    data_t out_data_o;
    logic  out_first_o;
    logic  out_last_o;
    adr_t  out_adr_o;
    tga_t  out_tga_o;
    tgc_t  out_tgc_o;

    int    n_vec = 0;
    int    n_err = 0;
    flit_t exp_q[$];
    data_t got_q[$];
    flit_t cur;

    wb_slave_pipeline_rx_if bus ();

    wb_slave_pipeline_rx #(
        .N_WAIT_CYCLE_GRANT (N_WAIT),
        .N_MAX_BEAT         (N_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_first_o (out_first_o),
        .out_last_o  (out_last_o),
        .out_adr_o   (out_adr_o),
        .out_tga_o   (out_tga_o),
        .out_tgc_o   (out_tgc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_ctl"},
            {bus.gnt_wb_o, bus.ACK_O, bus.ERR_O, bus.RTY_O,
             bus.STALL_O, out_valid_o, out_first_o, out_last_o},
            8'b0000_1000);
        chk({nm, "_dat"},
            {bus.DAT_O, out_data_o}, 64'h0);
        chk({nm, "_side"},
            {out_adr_o, out_tga_o, out_tgc_o}, 64'h0);
    endtask

    // Drives one whole bus cycle and records what must come out.
    task automatic send_pkt(input int n, input data_t d0,
                            input adr_t adr, input tga_t tga,
                            input tgc_t tgc, input int rd_idx);
        int    w;
        int    c;
        bit    bad;
        bit    exp_ack;
        data_t stored[$];
        flit_t f;
        w   = 0;
        c   = 0;
        bad = 0;
        bus.CYC_I = 1'b1;
        bus.ADR_I = adr;
        bus.TGA_I = tga;
        bus.TGC_I = tgc;
        while (!bus.gnt_wb_o && w < 20) begin
            tick();
            w++;
        end
        chk("gnt_latency", 64'(w), 64'(N_WAIT + 2));
        chk("stall_at_gnt", bus.STALL_O, 1'b0);
        for (int j = 0; j < n; j++) begin
            bus.STB_I = 1'b1;
            bus.WE_I  = (j != rd_idx);
            bus.DAT_I = d0 + data_t'(j);
            exp_ack   = 1'b0;
            if (j != rd_idx && c < N_MAX) begin
                exp_ack = 1'b1;
                stored.push_back(d0 + data_t'(j));
                c++;
            end else begin
                bad = 1;
            end
            tick();
            chk("beat_resp", {bus.ACK_O, bus.ERR_O},
                {exp_ack, !exp_ack});
        end
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.CYC_I = 1'b0;
        if (!bad && c > 0) begin
            for (int k = 0; k < c; k++) begin
                f.data  = stored[k];
                f.first = (k == 0);
                f.last  = (k == c - 1);
                f.adr   = adr;
                f.tga   = tga;
                f.tgc   = tgc;
                exp_q.push_back(f);
            end
        end
    endtask

    task automatic drain_wait(input logic [3:0] pat);
        for (int i = 0; i < 64; i++) begin
            out_ready_i = pat[i % 4];
            tick();
            if (i == 0) begin
                chk("gnt_drop", bus.gnt_wb_o, 1'b0);
                if (exp_q.size() > 0)
                    chk("drain_latency", out_valid_o, 1'b1);
            end
            if (exp_q.size() == 0 && !out_valid_o) begin
                out_ready_i = 1'b0;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: %0d flits left", exp_q.size());
        out_ready_i = 1'b0;
    endtask

    task automatic pulse(input int len, input int exp_gnt);
        int g;
        int s;
        g = 0;
        s = 0;
        bus.CYC_I = 1'b1;
        for (int i = 1; i <= len + 2; i++) begin
            tick();
            if (bus.gnt_wb_o) g++;
            if (!bus.STALL_O) s++;
            if (i == len) bus.CYC_I = 1'b0;
        end
        chk("pulse_gnt", 64'(g), 64'(exp_gnt));
        chk("pulse_stall", 64'(s), 64'(exp_gnt));
        chk("pulse_noflit", out_valid_o, 1'b0);
    endtask

    // Per-cycle flit checker against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_flit: got %0h expected none",
                             out_data_o);
                end else begin
                    cur = exp_q[0];
                    chk("flit_data", out_data_o, cur.data);
                    chk("flit_marks", {out_first_o, out_last_o},
                        {cur.first, cur.last});
                    chk("flit_side",
                        {out_adr_o, out_tga_o, out_tgc_o},
                        {cur.adr, cur.tga, cur.tgc});
                    if (out_ready_i) begin
                        got_q.push_back(out_data_o);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.ADR_I = '0;
        bus.DAT_I = '0;
        bus.SEL_I = '1;
        bus.TGA_I = '0;
        bus.TGC_I = '0;
        bus.CTI_I = '0;
        #1 rst = 1'b0;
        #2 check_reset_vals("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        send_pkt(5, 32'hA0, 32'h12, 4'd3, 4'd5, -1);
        chk("tga_latched", out_tga_o, 4'd3);
        drain_wait(4'b1111);
        chk("t1_count", 64'(got_q.size()), 64'd5);
        chk("t1_head", got_q[0], 32'hA0);
        chk("t1_tail", got_q[4], 32'hA4);

        send_pkt(5, 32'hC0, 32'h34, 4'd1, 4'd2, -1);
        drain_wait(4'b1001);
        chk("t2_count", 64'(got_q.size()), 64'd10);
        chk("t2_tail", got_q[9], 32'hC4);

        out_ready_i = 1'b1;
        send_pkt(6, 32'hB0, 32'h40, 4'd2, 4'd0, -1);
        drain_wait(4'b1111);
        chk("ovf_noflit", 64'(got_q.size()), 64'd10);

        send_pkt(1, 32'h77, 32'h44, 4'd4, 4'd4, 0);
        drain_wait(4'b1111);
        chk("rd_noflit", 64'(got_q.size()), 64'd10);

        pulse(3, 0);
        pulse(5, 2);

        send_pkt(5, 32'hD0, 32'h50, 4'd6, 4'd3, -1);
        tick();
        out_ready_i = 1'b1;
        tick();
        tick();
        chk("pre_rst_flit", {out_data_o, out_first_o},
            {32'hD2, 1'b0});
        rst = 1'b0;
        exp_q.delete();
        #1 check_reset_vals("mid_drain_rst");
        out_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        send_pkt(2, 32'hE0, 32'h56, 4'd7, 4'd1, -1);
        drain_wait(4'b1111);
        chk("post_rst_tail", got_q[got_q.size() - 1], 32'hE1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
